// File: rtl/button_event_scheduler.sv
// button_event_scheduler
//   Queues one pending request per button from one-cycle press pulses and
//   serves the requests one at a time, in round-robin order, as a valid/ready
//   event stream. After every accepted event the block stays idle for GAP
//   extra cycles. Presses that arrive for a button that already has a request
//   queued are lost, and drop_cnt counts them (saturating).
//
//   Handshake: the event stream is strict valid/ready. Once evt_valid is high,
//   evt_valid and evt_id hold until the cycle in which evt_ready is also high;
//   the transfer happens on that rising edge. evt_ready is ignored while
//   evt_valid is low.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   press      [N]     one-cycle press pulses, bit i = button i
//   en_mask    [N]     1 = button i may be queued and offered
//   evt_valid  out     event offered
//   evt_id     [ID_W]  index of the offered button
//   evt_ready  in      consumer accepts the event
//   pending    [N]     pending-request bits
//   busy       out     FSM is not idle
//   drop_cnt   [CNT_W] saturating count of lost presses
//   dbg_state  [2]     FSM state (0 idle, 1 offer, 2 gap)
module button_event_scheduler #(
  parameter int N     = 4,
  parameter int GAP   = 10,
  parameter int CNT_W = 8,
  parameter int ID_W  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     press,
  input  logic [N-1:0]     en_mask,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N-1:0]     pending,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int          GW      = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  state_t            state_q, state_d;
  logic              evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]   evt_id_q, evt_id_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [N-1:0]      pending_q, pending_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic              accept;
  logic [N-1:0]      clr, set, drop, eligible;
  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  int unsigned       idx;
  int unsigned       ndrop;
  int unsigned       sum;

  assign accept   = evt_valid_q & evt_ready;
  assign set      = press & en_mask;
  assign eligible = pending_q & en_mask;

  always_comb begin
    clr = '0;
    if (accept) clr[evt_id_q] = 1'b1;
  end

  // A press that lands on the same edge as the accept of its own button is a
  // fresh request, not a drop.
  assign drop      = set & pending_q & ~clr;
  assign pending_d = (pending_q & ~clr) | set;

  always_comb begin
    ndrop = 0;
    for (int i = 0; i < N; i++) begin
      if (drop[i]) ndrop = ndrop + 1;
    end
    sum = 32'(drop_cnt_q) + ndrop;
    drop_cnt_d = (sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(sum);
  end

  // Round-robin pick: first eligible index starting at rr, wrapping mod N.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int j = 0; j < N; j++) begin
      idx = 32'(rr_q) + 32'(j);
      if (idx >= 32'(N)) idx = idx - 32'(N);
      if (!sel_found && eligible[idx]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_d        = rr_q;
    gap_d       = gap_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          evt_id_d    = sel_idx;
          evt_valid_d = 1'b1;
          state_d     = S_OFFER;
        end
      end
      S_OFFER: begin
        if (accept) begin
          evt_valid_d = 1'b0;
          rr_d        = (evt_id_q == ID_W'(N - 1)) ? '0 : evt_id_q + 1'b1;
          if (GAP > 0) begin
            gap_d   = GW'(GAP);
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(1)) state_d = S_IDLE;
        else                 gap_d   = gap_q - 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_q        <= '0;
      pending_q   <= '0;
      drop_cnt_q  <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      rr_q        <= rr_d;
      pending_q   <= pending_d;
      drop_cnt_q  <= drop_cnt_d;
      gap_q       <= gap_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: two instances (GAP=10 and GAP=0) share
// one stimulus stream. A reference model tracks requests as a bit set, the
// offer as "offering/id", and the idle gap as a count of forbidden cycles.
// Each new offer pushes its expected id into a per-instance queue; the
// monitor pops on every handshake and compares per-cycle outputs.
module tb_button_event_scheduler;
  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int ID_W  = 2;
  localparam int GAP0  = 10;
  localparam int GAP1  = 0;
  localparam int SAT   = 255;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    press;
  logic [N-1:0]    en_mask;
  logic            evt_ready;

  logic            ev_valid [2];
  logic [ID_W-1:0] ev_id    [2];
  logic [N-1:0]    pend     [2];
  logic            bsy      [2];
  logic [CNT_W-1:0] dcnt    [2];
  logic [1:0]      dbg      [2];

  int total;
  int bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  button_event_scheduler #(.N(N), .GAP(GAP0), .CNT_W(CNT_W)) u0 (
    .clk(clk), .rst_n(rst_n), .press(press), .en_mask(en_mask),
    .evt_valid(ev_valid[0]), .evt_id(ev_id[0]), .evt_ready(evt_ready),
    .pending(pend[0]), .busy(bsy[0]), .drop_cnt(dcnt[0]), .dbg_state(dbg[0])
  );

  button_event_scheduler #(.N(N), .GAP(GAP1), .CNT_W(CNT_W)) u1 (
    .clk(clk), .rst_n(rst_n), .press(press), .en_mask(en_mask),
    .evt_valid(ev_valid[1]), .evt_id(ev_id[1]), .evt_ready(evt_ready),
    .pending(pend[1]), .busy(bsy[1]), .drop_cnt(dcnt[1]), .dbg_state(dbg[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0]    m_pend  [2];
  int              m_drops [2];
  int              m_rr    [2];
  int              m_oid   [2];
  int              m_hold  [2];
  bit              m_off   [2];
  int              m_offers[2];
  logic [ID_W-1:0] exp_q0[$];
  logic [ID_W-1:0] exp_q1[$];

  function automatic int gap_of(input int u);
    return (u == 0) ? GAP0 : GAP1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_pend[u] = '0; m_drops[u] = 0; m_rr[u] = 0;
      m_oid[u] = 0; m_hold[u] = 0; m_off[u] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_step(input int u);
    logic [N-1:0] clr;
    logic [N-1:0] elig;
    bit acc;
    int pick;
    acc  = m_off[u] && evt_ready;
    clr  = '0;
    if (acc) clr[m_oid[u]] = 1'b1;
    elig = m_pend[u] & en_mask;
    if (m_off[u]) begin
      if (acc) begin
        m_off[u]  = 0;
        m_rr[u]   = (m_oid[u] + 1) % N;
        m_hold[u] = gap_of(u);
      end
    end else if (m_hold[u] > 0) begin
      m_hold[u]--;
    end else if (elig != '0) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && elig[(m_rr[u] + k) % N]) pick = (m_rr[u] + k) % N;
      end
      m_off[u] = 1;
      m_oid[u] = pick;
      m_offers[u]++;
      if (u == 0) exp_q0.push_back(ID_W'(pick));
      else        exp_q1.push_back(ID_W'(pick));
    end
    for (int i = 0; i < N; i++) begin
      if (press[i] && en_mask[i]) begin
        if (m_pend[u][i] && !clr[i]) begin
          if (m_drops[u] < SAT) m_drops[u]++;
        end
      end
    end
    m_pend[u] = (m_pend[u] & ~clr) | (press & en_mask);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [ID_W-1:0] e;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d evt_valid", u), int'(ev_valid[u]), int'(m_off[u]));
      chk($sformatf("u%0d busy", u), int'(bsy[u]), int'(m_off[u] || m_hold[u] > 0));
      chk($sformatf("u%0d pending", u), int'(pend[u]), int'(m_pend[u]));
      chk($sformatf("u%0d drop_cnt", u), int'(dcnt[u]), m_drops[u]);
      if (ev_valid[u] && m_off[u])
        chk($sformatf("u%0d evt_id", u), int'(ev_id[u]), m_oid[u]);
      if (rst_n && ev_valid[u] && evt_ready) begin
        if ((u == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          total++; bad++;
          $display("FAIL u%0d accept: got id %0d expected no event", u, ev_id[u]);
        end else begin
          e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("u%0d accepted id", u), int'(ev_id[u]), int'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [N-1:0] p);
    press = p;
    tick(1);
    press = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int off_before;
    m_offers[0] = 0; m_offers[1] = 0;
    total = 0; bad = 0;
    rst_n = 1'b0; press = '0; en_mask = 4'b1111; evt_ready = 1'b0;
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // single press, ready high
    evt_ready = 1'b1;
    pulse(4'b0100);
    tick(20);

    // simultaneous presses
    pulse(4'b1011);
    tick(50);

    // backpressure on id 1 while button 0 keeps pressing
    evt_ready = 1'b0;
    pulse(4'b0010);
    tick(2);
    for (int c = 0; c < 10; c++) begin
      pulse(4'b0001);
      tick(1);
    end
    evt_ready = 1'b1;
    tick(40);

    // masked button, then a pending request parked behind a cleared mask
    en_mask = 4'b1110;
    pulse(4'b0001);
    tick(3);
    en_mask = 4'b1111;
    evt_ready = 1'b0;
    pulse(4'b0010);
    tick(2);
    pulse(4'b0100);
    en_mask = 4'b1010;
    evt_ready = 1'b1;
    tick(25);
    en_mask = 4'b1111;
    tick(20);

    // same-edge accept and new press of the same button
    evt_ready = 1'b0;
    pulse(4'b1000);
    tick(3);
    press = 4'b1000;
    evt_ready = 1'b1;
    tick(1);
    press = '0;
    tick(30);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      press = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      evt_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) en_mask = 4'($urandom_range(0, 15));
      tick(1);
    end
    press = '0; en_mask = 4'b1111; evt_ready = 1'b1;
    tick(40);

    // drop counter saturation
    evt_ready = 1'b0;
    for (int c = 0; c < 300; c++) pulse(4'b1000);
    tick(2);
    chk("u0 drop saturated", int'(dcnt[0]), SAT);
    chk("u1 drop saturated", int'(dcnt[1]), SAT);
    evt_ready = 1'b1;
    tick(40);

    // reset asserted while both instances are offering
    evt_ready = 1'b0;
    pulse(4'b0001);
    tick(2);
    #3;
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d async rst valid", u), int'(ev_valid[u]), 0);
      chk($sformatf("u%0d async rst pending", u), int'(pend[u]), 0);
      chk($sformatf("u%0d async rst drop", u), int'(dcnt[u]), 0);
      chk($sformatf("u%0d async rst busy", u), int'(bsy[u]), 0);
    end
    tick(2);
    rst_n = 1'b1;
    off_before = m_offers[0] + m_offers[1];
    evt_ready = 1'b1;
    tick(20);
    chk("no event after reset", m_offers[0] + m_offers[1], off_before);

    // final drain: every predicted event must have been accepted
    tick(30);
    chk("u0 exp queue empty", exp_q0.size(), 0);
    chk("u1 exp queue empty", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
